ram_bus_initiator: RTL
======================

# ram_bus_initiator

Fabric-side initiator for the RamBus register interface (APB-style: select, latch/enable, write/read, 14-bit address, 32-bit data, ack). It issues single read/write transactions from a valid/ready command port and returns read data, error status and counters on a response port. Lets fabric logic or a bench drive a RamBus responder such as the DM main-ports block when the MSS is absent or busy.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: ACCESS-phase cycles without RamBusAck before abort (1..65535).
- ERR_DATA, 32'hDEADBEEF: rsp_rdata value returned on timeout.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  14  RamBus word address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data (0 for writes, ERR_DATA on timeout).
- rsp_err  out  1  transaction timed out; qualified by rsp_valid.
- RamBusnCs  out  1  bus select; active-high despite the name (drives the responder's select input directly).
- RamBusLatch  out  1  enable/access phase strobe.
- RamBusWrnRd  out  1  1 = write, 0 = read.
- RamBusAddress  out  14  transaction address.
- RamBusDataIn  out  32  write data to responder.
- RamBusDataOut  in  32  read data from responder.
- RamBusAck  in  1  responder ready/ack.
- txn_count  out  16  completed transactions (success or timeout), wraps.
- err_count  out  8  timeouts, saturates at 255.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1, all RamBus outputs 0. cmd_valid & cmd_ready captures cmd_write/addr/wdata into registers -> SETUP.
- SETUP (exactly 1 cycle): RamBusnCs=1, RamBusLatch=0, WrnRd/Address/DataIn from captured command; timeout counter cleared -> ACCESS.
- ACCESS: RamBusnCs=1, RamBusLatch=1, address/data/WrnRd held stable. RamBusAck sampled each rising edge:
  - Ack=1: latch RamBusDataOut (reads) or 0 (writes) into rsp_rdata, rsp_err=0 -> RESP.
  - Ack=0 and counter = TIMEOUT_CYCLES-1: rsp_rdata=ERR_DATA, rsp_err=1, err_count+1 (saturating) -> RESP.
  - else counter+1, stay.
- RESP (1 cycle): rsp_valid=1, RamBusnCs=0, RamBusLatch=0; txn_count+1 (wraps 65535->0) -> IDLE.
- RamBusWrnRd, RamBusAddress, RamBusDataIn return to 0 whenever RamBusnCs=0.
- cmd_ready=0 in SETUP/ACCESS/RESP; commands presented then are not consumed and must be held by the source.
- Ack arriving outside ACCESS is ignored. Ack on the same edge the timeout would fire: ack wins, no error.
- No backpressure on the response port; consumer must take rsp_valid when pulsed.

## Timing
- Reset (rst=1 at a rising edge): state IDLE, cmd_ready=1 on the following cycle, rsp_valid=0, rsp_err=0, rsp_rdata=0, all RamBus outputs 0, txn_count=0, err_count=0, timeout counter 0.
- Reset mid-transaction: transaction dropped, no rsp_valid, RamBusnCs/Latch drop to 0 on the reset edge.
- Accept at edge 0 -> SETUP visible cycle 1 -> ACCESS cycle 2. Ack high in cycle 2 -> rsp_valid in cycle 3 -> cmd_ready in cycle 4.
- Minimum command-to-response latency 3 cycles; throughput one transaction per 4 cycles with zero-wait responder.
- Each wait cycle (Ack=0 in ACCESS) adds 1 cycle. Timeout: rsp_valid exactly TIMEOUT_CYCLES+2 cycles after accept.
- All outputs registered; no combinational path from RamBus inputs to any output.

## Test plan
- Zero-wait write: cmd write addr 0x0010 data 0x12345678, Ack tied 1 -> SETUP 1 cycle (nCs=1, Latch=0), ACCESS 1 cycle, rsp_valid at cycle 3 with rdata 0, err 0; txn_count=1.
- Read with 3 wait states: read addr 0x3FFF, Ack raised on 4th ACCESS cycle with DataOut 0xCAFEF00D -> rsp_rdata 0xCAFEF00D at cycle 6, address held 0x3FFF throughout ACCESS.
- Timeout: TIMEOUT_CYCLES=4, Ack held 0 -> rsp_valid at cycle 6, rsp_err=1, rsp_rdata=0xDEADBEEF, err_count=1; Ack on final cycle instead -> err 0.
- Back-to-back: cmd_valid held with 3 commands, zero-wait responder -> accepts at cycles 0, 4, 8; cmd_ready low otherwise; txn_count=3.
- Reset in ACCESS: assert rst mid-wait -> no rsp_valid, RamBus outputs 0 next cycle, counters 0, next command completes normally.
- Counters: 65536 zero-wait transactions -> txn_count wraps to 0; 300 timeouts -> err_count stays 255.

Source files
------------

// File: rtl/ram_bus_initiator.sv
// Fabric-side RamBus initiator: takes single read/write commands on a valid/ready
// port, runs SETUP/ACCESS on the RamBus and returns data, timeout status and counters.
module ram_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [13:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        RamBusnCs,
  output logic        RamBusLatch,
  output logic        RamBusWrnRd,
  output logic [13:0] RamBusAddress,
  output logic [31:0] RamBusDataIn,
  input  logic [31:0] RamBusDataOut,
  input  logic        RamBusAck,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_write;
  logic [13:0] r_addr;
  logic [31:0] r_wdata;
  logic [15:0] r_tmo_cnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [15:0] r_txn_cnt;
  logic [7:0]  r_err_cnt;
  logic        w_accept;
  logic        w_timeout;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  // Ack takes priority: a timeout only counts when Ack is low on the final cycle.
  assign w_timeout = (r_state == S_ACCESS) && !RamBusAck && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: if (RamBusAck || w_timeout) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tmo_cnt <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_txn_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      case (r_state)
        S_SETUP: r_tmo_cnt <= '0;
        S_ACCESS: begin
          if (RamBusAck) begin
            r_rdata <= r_write ? 32'd0 : RamBusDataOut;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= ERR_DATA;
            r_err   <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        S_RESP: r_txn_cnt <= r_txn_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Bus outputs decode purely from registered state so RamBus inputs never reach them.
  always_comb begin
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    RamBusnCs     = 1'b0;
    RamBusLatch   = 1'b0;
    RamBusWrnRd   = 1'b0;
    RamBusAddress = '0;
    RamBusDataIn  = '0;
    case (r_state)
      S_IDLE: cmd_ready = 1'b1;
      S_SETUP: begin
        RamBusnCs     = 1'b1;
        RamBusWrnRd   = r_write;
        RamBusAddress = r_addr;
        RamBusDataIn  = r_wdata;
      end
      S_ACCESS: begin
        RamBusnCs     = 1'b1;
        RamBusLatch   = 1'b1;
        RamBusWrnRd   = r_write;
        RamBusAddress = r_addr;
        RamBusDataIn  = r_wdata;
      end
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign txn_count = r_txn_cnt;
  assign err_count = r_err_cnt;

endmodule
